seq_event_logger: RTL and testbench

Downstream consumer of the 1011 sequence detector's `seq_seen` output. Turns each detection into a timestamped event, buffers events in a small first-word-fall-through FIFO, and presents them on a valid/ready interface. Also keeps saturating counts of all detections and of events dropped because the FIFO was full. Sits between the detector and the host/monitor logic that reads detection events.

---
 rtl/seq_event_logger.sv | 103 ++++++++++
 tb/tb_seq_event_logger.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_event_logger.sv
// Timestamped event logger for the sequence detector: edge-detects seq_seen,
// queues the timestamp of each detection in a FWFT FIFO and keeps saturating counts.
module seq_event_logger #(
  parameter int TS_WIDTH  = 16,
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       seq_seen,
  input  logic                       clear,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [TS_WIDTH-1:0]        evt_timestamp,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic [CNT_WIDTH-1:0]       total_count,
  output logic [CNT_WIDTH-1:0]       drop_count,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [TS_WIDTH-1:0]  r_ts;
  logic                 r_seq_d;
  logic [TS_WIDTH-1:0]  r_mem [DEPTH];
  logic [AW-1:0]        r_wptr;
  logic [AW-1:0]        r_rptr;
  logic [LW-1:0]        r_level;
  logic [CNT_WIDTH-1:0] r_total;
  logic [CNT_WIDTH-1:0] r_drop;
  logic                 r_ovf;

  logic w_event;
  logic w_nonempty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign w_event    = seq_seen & ~r_seq_d;
  assign w_nonempty = (r_level != '0);
  assign w_full     = (r_level == FULL_LVL);
  assign w_pop      = w_nonempty & evt_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_push     = w_event & (~w_full | w_pop);
  assign w_drop     = w_event & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ts    <= '0;
      r_seq_d <= 1'b0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_total <= '0;
      r_drop  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_ts    <= r_ts + 1'b1;
      r_seq_d <= seq_seen;
      if (clear) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_level <= '0;
        r_total <= '0;
        r_drop  <= '0;
        r_ovf   <= 1'b0;
      end else begin
        if (w_push) r_wptr <= r_wptr + 1'b1;
        if (w_pop)  r_rptr <= r_rptr + 1'b1;
        case ({w_push, w_pop})
          2'b10:   r_level <= r_level + 1'b1;
          2'b01:   r_level <= r_level - 1'b1;
          default: r_level <= r_level;
        endcase
        if (w_event) r_total <= sat_inc(r_total);
        if (w_drop) begin
          r_drop <= sat_inc(r_drop);
          r_ovf  <= 1'b1;
        end
      end
    end
  end

  // Storage carries no reset; unread slots are masked by the level counter.
  always_ff @(posedge clk) begin
    if (reset && !clear && w_push) r_mem[r_wptr] <= r_ts;
  end

  assign evt_valid     = w_nonempty;
  assign evt_timestamp = w_nonempty ? r_mem[r_rptr] : '0;
  assign fifo_level    = r_level;
  assign total_count   = r_total;
  assign drop_count    = r_drop;
  assign overflow      = r_ovf;

endmodule

// File: tb/tb_seq_event_logger.sv
// Directed bench for seq_event_logger: default-sized instance plus a narrow
// instance for timestamp wrap and counter saturation.
module tb_seq_event_logger;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b0, seq_seen = 1'b0, clear = 1'b0, evt_ready = 1'b0;
  logic        evt_valid, overflow;
  logic [15:0] evt_timestamp;
  logic [2:0]  fifo_level;
  logic [7:0]  total_count, drop_count;

  logic        s_reset = 1'b0, s_seq = 1'b0, s_clear = 1'b0, s_ready = 1'b0;
  logic        s_valid, s_ovf;
  logic [3:0]  s_ts;
  logic [2:0]  s_level;
  logic [1:0]  s_total, s_drop;

  int n_checks = 0;
  int n_err    = 0;

  seq_event_logger #(.TS_WIDTH(16), .DEPTH(4), .CNT_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .seq_seen(seq_seen), .clear(clear),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_timestamp(evt_timestamp),
    .fifo_level(fifo_level), .total_count(total_count), .drop_count(drop_count),
    .overflow(overflow)
  );

  seq_event_logger #(.TS_WIDTH(4), .DEPTH(4), .CNT_WIDTH(2)) dut_s (
    .clk(clk), .reset(s_reset), .seq_seen(s_seq), .clear(s_clear),
    .evt_valid(s_valid), .evt_ready(s_ready), .evt_timestamp(s_ts),
    .fifo_level(s_level), .total_count(s_total), .drop_count(s_drop),
    .overflow(s_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse();
    seq_seen = 1'b1;
    step();
    seq_seen = 1'b0;
  endtask

  task automatic spulse();
    s_seq = 1'b1;
    step();
    s_seq = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, evt_valid, 0);
    chk({tag, "_ts"},    evt_timestamp, 0);
    chk({tag, "_level"}, fifo_level, 0);
    chk({tag, "_total"}, total_count, 0);
    chk({tag, "_drop"},  drop_count, 0);
    chk({tag, "_ovf"},   overflow, 0);
  endtask

  logic [15:0] exp_q [4];

  initial begin
    // Reset; the cycle after the reset edge has ts=0.
    step();
    reset = 1'b1;
    chk_all_zero("rst");

    // Single event in cycle 5.
    step(5);
    pulse();
    chk("t1_valid", evt_valid, 1);
    chk("t1_ts",    evt_timestamp, 5);
    chk("t1_total", total_count, 1);
    chk("t1_level", fifo_level, 1);
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    chk("t1_valid_after_pop", evt_valid, 0);
    chk("t1_ts_after_pop",    evt_timestamp, 0);

    // Fill and overflow: pulses in cycles 10,12,14,16,18.
    reset = 1'b0;
    step();
    reset = 1'b1;
    step(10);
    pulse();
    for (int i = 0; i < 4; i++) begin
      step();
      pulse();
    end
    chk("t2_level", fifo_level, 4);
    chk("t2_total", total_count, 5);
    chk("t2_drop",  drop_count, 1);
    chk("t2_ovf",   overflow, 1);
    exp_q[0] = 16'd10; exp_q[1] = 16'd12; exp_q[2] = 16'd14; exp_q[3] = 16'd16;
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_drain%0d_valid", i), evt_valid, 1);
      chk($sformatf("t2_drain%0d_ts", i), evt_timestamp, exp_q[i]);
      step();
    end
    evt_ready = 1'b0;
    chk("t2_empty_valid", evt_valid, 0);
    chk("t2_empty_level", fifo_level, 0);
    chk("t2_ovf_sticky",  overflow, 1);

    // Clear (cycle 23), then fill with 24,26,28,30.
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk_all_zero("clr");
    pulse();
    for (int i = 0; i < 3; i++) begin
      step();
      pulse();
    end
    chk("t3_full_level", fifo_level, 4);
    step();
    // Cycle 32: event together with pop while full.
    seq_seen = 1'b1;
    evt_ready = 1'b1;
    step();
    seq_seen = 1'b0;
    evt_ready = 1'b0;
    chk("t3_level", fifo_level, 4);
    chk("t3_drop",  drop_count, 0);
    chk("t3_ovf",   overflow, 0);
    chk("t3_total", total_count, 5);
    exp_q[0] = 16'd26; exp_q[1] = 16'd28; exp_q[2] = 16'd30; exp_q[3] = 16'd32;
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3_drain%0d_ts", i), evt_timestamp, exp_q[i]);
      step();
    end
    evt_ready = 1'b0;
    chk("t3_empty_valid", evt_valid, 0);

    // Level held 3 cycles (38..40) logs one entry.
    clear = 1'b1;
    step();
    clear = 1'b0;
    seq_seen = 1'b1;
    step(3);
    seq_seen = 1'b0;
    chk("t4_level", fifo_level, 1);
    chk("t4_total", total_count, 1);
    chk("t4_ts",    evt_timestamp, 38);
    step();
    // Clear with a new rising edge, level kept high past the clear.
    clear = 1'b1;
    seq_seen = 1'b1;
    step();
    clear = 1'b0;
    chk_all_zero("t4_clr");
    step();
    seq_seen = 1'b0;
    chk("t4_noretrig_level", fifo_level, 0);
    chk("t4_noretrig_total", total_count, 0);

    // Reset with 3 entries queued.
    step();
    pulse();
    step();
    pulse();
    step();
    pulse();
    chk("t6_level_pre", fifo_level, 3);
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk_all_zero("t6_rst");
    step(3);
    pulse();
    chk("t6_valid", evt_valid, 1);
    chk("t6_ts",    evt_timestamp, 3);
    chk("t6_total", total_count, 1);
    chk("t6_level", fifo_level, 1);

    // Narrow instance: wrap at ts=15 and 2-bit saturation.
    step();
    s_reset = 1'b1;
    chk("t5_rst_level", s_level, 0);
    step(15);
    spulse();
    step();
    spulse();
    chk("t5_level", s_level, 2);
    chk("t5_total2", s_total, 2);
    chk("t5_head0", s_ts, 15);
    s_ready = 1'b1;
    step();
    chk("t5_head1", s_ts, 1);
    step();
    s_ready = 1'b0;
    chk("t5_empty", s_valid, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      spulse();
    end
    chk("t5_total_sat", s_total, 3);
    chk("t5_level3", s_level, 3);
    chk("t5_drop", s_drop, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
